// File: rtl/vec_bit_serializer_pkg.sv
// Shared types and helpers for the vector bit serializer.
// Holds the FSM state encoding and the index-width calculation.
package vec_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } vec_ser_state_t;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 64;

  // A 1-bit vector still needs a 1-bit index port.
  function automatic int idx_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/vec_bit_serializer_if.sv
// Bus bundle for the serializer: vector-in handshake, bit-out handshake and status.
// Handshake rule for both channels: a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds its data stable while valid=1
// and ready=0, and the consumer may hold ready low for any number of cycles.
interface vec_bit_serializer_if
  import vec_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             in_msb_first;

  logic [WIDTH-1:0] outv;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  modport slave (
    input  in_valid,
    input  in_vec,
    input  in_msb_first,
    input  out_ready,
    output in_ready,
    output outv,
    output out_bit,
    output out_valid,
    output out_idx,
    output out_last,
    output busy
  );

  modport master (
    output in_valid,
    output in_vec,
    output in_msb_first,
    output out_ready,
    input  in_ready,
    input  outv,
    input  out_bit,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  busy
  );

endinterface

// File: rtl/vec_bit_serializer_index_ctr.sv
// Loadable up/down bit-index counter for the serializer.
// at_end_o flags the final position for the current direction (dir_i=1 counts down).
module vec_bit_index_ctr
  import vec_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [IDX_W-1:0] load_val_i,
  input  logic             step_i,
  input  logic             dir_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             at_end_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Load wins over step: a new vector arriving on the last beat restarts the index.
  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = load_val_i;
    end else if (step_i) begin
      idx_d = dir_i ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o    = idx_q;
  assign at_end_o = dir_i ? (idx_q == '0) : (idx_q == LAST_IDX);

endmodule

// File: rtl/vec_bit_serializer.sv
// Captures a WIDTH-bit vector over valid/ready and replays it one bit per beat,
// MSB- or LSB-first per transfer, with index/last flags and no bubble between vectors.
module vec_bit_serializer
  import vec_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vec_bit_serializer_if.slave  bus,
  output vec_ser_state_t       state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("vec_bit_serializer: WIDTH out of range 1..64");
  end

  vec_ser_state_t   state_q;
  logic [WIDTH-1:0] outv_q;
  logic             msb_q;

  logic             in_shift;
  logic             at_end;
  logic             out_last;
  logic             in_ready;
  logic             accept;
  logic             beat;
  logic             last_beat;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] start_idx;
  logic [WIDTH-1:0] shifted;

  assign in_shift  = (state_q == SHIFT);
  assign out_last  = in_shift & at_end;
  // Ready in SHIFT only while the final beat is leaving, so the next vector
  // loads on the same edge and streaming continues without an idle cycle.
  assign in_ready  = ~in_shift | (out_last & bus.out_ready);
  assign accept    = bus.in_valid & in_ready;
  assign beat      = in_shift & bus.out_ready;
  assign last_beat = beat & at_end;
  assign start_idx = bus.in_msb_first ? LAST_IDX : '0;

  vec_bit_index_ctr #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_idx_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (start_idx),
    .step_i     (beat & ~at_end),
    .dir_i      (msb_q),
    .idx_o      (idx),
    .at_end_o   (at_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      outv_q  <= '0;
      msb_q   <= 1'b0;
    end else begin
      if (accept) begin
        state_q <= SHIFT;
        outv_q  <= bus.in_vec;
        msb_q   <= bus.in_msb_first;
      end else if (last_beat) begin
        state_q <= IDLE;
      end
    end
  end

  // Shift rather than index so a 1-bit vector needs no special-case select.
  assign shifted = outv_q >> idx;

  assign bus.in_ready  = in_ready;
  assign bus.outv      = outv_q;
  assign bus.out_valid = in_shift;
  assign bus.busy      = in_shift;
  assign bus.out_last  = out_last;
  assign bus.out_idx   = in_shift ? idx : '0;
  assign bus.out_bit   = in_shift & shifted[0];
  assign state_o       = state_q;

endmodule

// File: tb/tb_vec_bit_serializer.sv
// Directed bench for vec_bit_serializer: a WIDTH=8 and a WIDTH=1 instance share
// clock and reset; a row table drives one cycle per row, then reset-mid-transfer by hand.
module tb_vec_bit_serializer;
  import vec_ser_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vec_bit_serializer_if #(.WIDTH(8)) bus8 ();
  vec_bit_serializer_if #(.WIDTH(1)) bus1 ();
  vec_ser_state_t st8;
  vec_ser_state_t st1;

  vec_bit_serializer #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus8.slave),
    .state_o (st8)
  );

  vec_bit_serializer #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus1.slave),
    .state_o (st1)
  );

  typedef struct {
    logic       sel;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       msb;
    logic       out_ready;
    logic       e_rdy;
    logic       e_valid;
    logic       e_bit;
    logic [2:0] e_idx;
    logic       e_last;
    logic       e_busy;
    logic [7:0] e_outv;
  } row_t;

  row_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(input logic sel, input logic iv, input logic [7:0] vec,
                              input logic msb, input logic ordy, input logic e_rdy,
                              input logic e_valid, input logic e_bit, input logic [2:0] e_idx,
                              input logic e_last, input logic e_busy, input logic [7:0] e_outv);
    row_t r;
    r.sel = sel; r.in_valid = iv; r.in_vec = vec; r.msb = msb; r.out_ready = ordy;
    r.e_rdy = e_rdy; r.e_valid = e_valid; r.e_bit = e_bit; r.e_idx = e_idx;
    r.e_last = e_last; r.e_busy = e_busy; r.e_outv = e_outv;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic check8(input int row, input logic e_rdy, input logic e_valid,
                        input logic e_bit, input logic [2:0] e_idx, input logic e_last,
                        input logic e_busy, input logic [7:0] e_outv);
    check("in_ready",  row, 64'(bus8.in_ready),  64'(e_rdy));
    check("out_valid", row, 64'(bus8.out_valid), 64'(e_valid));
    check("out_bit",   row, 64'(bus8.out_bit),   64'(e_bit));
    check("out_idx",   row, 64'(bus8.out_idx),   64'(e_idx));
    check("out_last",  row, 64'(bus8.out_last),  64'(e_last));
    check("busy",      row, 64'(bus8.busy),      64'(e_busy));
    check("outv",      row, 64'(bus8.outv),      64'(e_outv));
  endtask

  task automatic apply_row(input row_t r, input int n);
    @(negedge clk);
    if (r.sel == 1'b0) begin
      bus8.in_valid = r.in_valid; bus8.in_vec = r.in_vec;
      bus8.in_msb_first = r.msb;  bus8.out_ready = r.out_ready;
      bus1.in_valid = 1'b0;       bus1.out_ready = 1'b1;
    end else begin
      bus1.in_valid = r.in_valid; bus1.in_vec = r.in_vec[0:0];
      bus1.in_msb_first = r.msb;  bus1.out_ready = r.out_ready;
      bus8.in_valid = 1'b0;       bus8.out_ready = 1'b1;
    end
    #1;
    if (r.sel == 1'b0) begin
      check8(n, r.e_rdy, r.e_valid, r.e_bit, r.e_idx, r.e_last, r.e_busy, r.e_outv);
    end else begin
      check("w1_in_ready",  n, 64'(bus1.in_ready),  64'(r.e_rdy));
      check("w1_out_valid", n, 64'(bus1.out_valid), 64'(r.e_valid));
      check("w1_out_bit",   n, 64'(bus1.out_bit),   64'(r.e_bit));
      check("w1_out_idx",   n, 64'(bus1.out_idx),   64'(r.e_idx));
      check("w1_out_last",  n, 64'(bus1.out_last),  64'(r.e_last));
      check("w1_busy",      n, 64'(bus1.busy),      64'(r.e_busy));
      check("w1_outv",      n, 64'(bus1.outv),      64'(r.e_outv[0]));
    end
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] v81;
    logic [7:0] v3c;
    int k;

    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_vec = '0; bus8.in_msb_first = 1'b0; bus8.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_vec = '0; bus1.in_msb_first = 1'b0; bus1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    a5  = 8'hA5;
    v81 = 8'h81;

    // Reset state.
    add(0, 0, 8'h00, 0, 1,  1, 0, 0, 3'd0, 0, 0, 8'h00);
    // LSB-first 8'hA5.
    add(0, 1, a5, 0, 1,  1, 0, 0, 3'd0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(0, 0, 8'h00, 0, 1,  (i == 7), 1, a5[i], 3'(i), (i == 7), 1, a5);
    add(0, 0, 8'h00, 0, 1,  1, 0, 0, 3'd0, 0, 0, a5);
    // MSB-first 8'h81 with a 3-cycle stall at idx 6.
    add(0, 1, v81, 1, 1,  1, 0, 0, 3'd0, 0, 0, a5);
    add(0, 0, 8'h00, 0, 1,  0, 1, v81[7], 3'd7, 0, 1, v81);
    for (int i = 0; i < 3; i++)
      add(0, 0, 8'h00, 0, 0,  0, 1, v81[6], 3'd6, 0, 1, v81);
    for (int i = 6; i >= 0; i--)
      add(0, 0, 8'h00, 0, 1,  (i == 0), 1, v81[i], 3'(i), (i == 0), 1, v81);
    add(0, 0, 8'h00, 0, 1,  1, 0, 0, 3'd0, 0, 0, v81);
    // Back-to-back: 8'hFF LSB-first then 8'h00 MSB-first.
    add(0, 1, 8'hFF, 0, 1,  1, 0, 0, 3'd0, 0, 0, v81);
    for (int i = 0; i < 8; i++)
      add(0, 1, 8'h00, 1, 1,  (i == 7), 1, 1, 3'(i), (i == 7), 1, 8'hFF);
    for (int i = 7; i >= 0; i--)
      add(0, 0, 8'h00, 0, 1,  (i == 0), 1, 0, 3'(i), (i == 0), 1, 8'h00);
    add(0, 0, 8'h00, 0, 1,  1, 0, 0, 3'd0, 0, 0, 8'h00);
    // WIDTH=1 instance: stream 1,0,1.
    add(1, 0, 8'h00, 0, 1,  1, 0, 0, 3'd0, 0, 0, 8'h00);
    add(1, 1, 8'h01, 0, 1,  1, 0, 0, 3'd0, 0, 0, 8'h00);
    add(1, 1, 8'h00, 1, 1,  1, 1, 1, 3'd0, 1, 1, 8'h01);
    add(1, 1, 8'h01, 0, 1,  1, 1, 0, 3'd0, 1, 1, 8'h00);
    add(1, 0, 8'h00, 0, 1,  1, 1, 1, 3'd0, 1, 1, 8'h01);
    add(1, 0, 8'h00, 0, 1,  1, 0, 0, 3'd0, 0, 0, 8'h01);

    for (int n = 0; n < vecs.size(); n++) apply_row(vecs[n], n);

    // Reset in the middle of 8'h3C, while beat 3 is presented.
    v3c = 8'h3C;
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.in_vec = v3c; bus8.in_msb_first = 1'b0; bus8.out_ready = 1'b1;
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
      #1;
      check8(900 + i, 1'b0, 1'b1, v3c[i], 3'(i), 1'b0, 1'b1, v3c);
    end
    #2 rst_n = 1'b0;
    #1 check8(910, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1 check8(911, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.in_vec = 8'hC3; bus8.in_msb_first = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    #1 check8(912, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 8'hC3);
    @(negedge clk);
    #1 check8(913, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 8'hC3);
    k = 0;
    while (bus8.out_valid && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check8(914, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
